// File: rtl/lock_ctrl.sv
// Keypad combination-lock sequencer: collects four digits, checks them against the password, and times unlock/lockout.
// Optional password change from the OPEN state is enabled by defining LOCK_CTRL_CHANGE_PW_EN.
module lock_ctrl #(
  parameter logic [15:0] PASSWORD    = 16'h1234,
  parameter int          MAX_WRONG   = 3,
  parameter logic [31:0] OPEN_CYCLES = 32'd50_000_000,
  parameter logic [31:0] LOCK_CYCLES = 32'd250_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] seg_1,
  output logic [3:0] seg_2,
  output logic [3:0] seg_3,
  output logic [3:0] seg_4,
  output logic [3:0] count_wrong,
  output logic       unlocked,
  output logic       alarm,
  output logic [2:0] dbg_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ENTRY   = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_OPEN    = 3'd3;
  localparam logic [2:0] S_LOCKOUT = 3'd4;
`ifdef LOCK_CTRL_CHANGE_PW_EN
  localparam logic [2:0] S_SETPW   = 3'd5;
  localparam logic [3:0] K_SET     = 4'd12;
`endif

  localparam logic [3:0] BLANK   = 4'hF;
  localparam logic [3:0] K_CLEAR = 4'd10;
  localparam logic [3:0] K_ENTER = 4'd11;
  localparam logic [3:0] MAX_W   = 4'(MAX_WRONG);

  logic [2:0]  state;
  logic [2:0]  idx;
  logic [31:0] timer;
  logic [3:0]  seg [4];
  logic [15:0] pw;
  logic [15:0] entered;
  logic [3:0]  cw_inc;
  logic        is_digit, is_clear, is_enter, is_set;
  logic        open_done, lock_done, full;

  always_comb begin
    is_digit  = key_valid && (key_code <= 4'd9);
    is_clear  = key_valid && (key_code == K_CLEAR);
    is_enter  = key_valid && (key_code == K_ENTER);
`ifdef LOCK_CTRL_CHANGE_PW_EN
    is_set    = key_valid && (key_code == K_SET);
`else
    is_set    = 1'b0;
`endif
    entered   = {seg[0], seg[1], seg[2], seg[3]};
    cw_inc    = count_wrong + 4'd1;
    full      = (idx == 3'd4);
    open_done = (timer == OPEN_CYCLES - 32'd1);
    lock_done = (timer == LOCK_CYCLES - 32'd1);
  end

`ifndef LOCK_CTRL_CHANGE_PW_EN
  assign pw = PASSWORD;
`endif

  // Single register block; every key decision is registered, so outputs never see key inputs combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= 3'd0;
      timer       <= 32'd0;
      for (int i = 0; i < 4; i++) seg[i] <= BLANK;
      count_wrong <= 4'd0;
      unlocked    <= 1'b0;
      alarm       <= 1'b0;
`ifdef LOCK_CTRL_CHANGE_PW_EN
      pw          <= PASSWORD;
`endif
    end else begin
      case (state)
        S_IDLE, S_ENTRY: begin
          if (is_digit && !full) begin
            seg[idx[1:0]] <= key_code;
            idx           <= idx + 3'd1;
            state         <= S_ENTRY;
          end else if (is_clear) begin
            for (int i = 0; i < 4; i++) seg[i] <= BLANK;
            idx   <= 3'd0;
            state <= S_IDLE;
          end else if (is_enter && full) begin
            state <= S_CHECK;
          end
        end

        // Keys are deliberately not looked at here, so a strobe during CHECK is dropped.
        S_CHECK: begin
          if (entered == pw) begin
            state       <= S_OPEN;
            count_wrong <= 4'd0;
            unlocked    <= 1'b1;
            timer       <= 32'd0;
          end else begin
            for (int i = 0; i < 4; i++) seg[i] <= BLANK;
            idx <= 3'd0;
            if (cw_inc < MAX_W) begin
              count_wrong <= cw_inc;
              state       <= S_IDLE;
            end else begin
              count_wrong <= MAX_W;
              alarm       <= 1'b1;
              timer       <= 32'd0;
              state       <= S_LOCKOUT;
            end
          end
        end

        S_OPEN: begin
          if (open_done || is_clear) begin
            unlocked <= 1'b0;
            for (int i = 0; i < 4; i++) seg[i] <= BLANK;
            idx   <= 3'd0;
            timer <= 32'd0;
            state <= S_IDLE;
`ifdef LOCK_CTRL_CHANGE_PW_EN
          end else if (is_set) begin
            for (int i = 0; i < 4; i++) seg[i] <= BLANK;
            idx   <= 3'd0;
            state <= S_SETPW;
`endif
          end else begin
            timer <= timer + 32'd1;
          end
        end

        S_LOCKOUT: begin
          if (lock_done) begin
            alarm       <= 1'b0;
            count_wrong <= 4'd0;
            timer       <= 32'd0;
            state       <= S_IDLE;
          end else begin
            timer <= timer + 32'd1;
          end
        end

`ifdef LOCK_CTRL_CHANGE_PW_EN
        // Timer is frozen while the new password is being typed; unlocked stays asserted.
        S_SETPW: begin
          if (is_digit && !full) begin
            seg[idx[1:0]] <= key_code;
            idx           <= idx + 3'd1;
          end else if (is_clear) begin
            for (int i = 0; i < 4; i++) seg[i] <= BLANK;
            idx <= 3'd0;
          end else if (is_enter && full) begin
            pw    <= entered;
            timer <= 32'd0;
            state <= S_OPEN;
          end
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

  assign seg_1     = seg[0];
  assign seg_2     = seg[1];
  assign seg_3     = seg[2];
  assign seg_4     = seg[3];
  assign dbg_state = state;

  logic unused_ok;
  assign unused_ok = is_set;

endmodule
